uart_tx: RTL and testbench

UART transmitter, the send-side partner of the team's UART receiver. It accepts a parallel byte through a start/busy handshake. It serialises the byte as start bit, data bits LSB first, optional parity, then stop bit(s), and drives line tx. Each bit is held for CLKS_PER_BIT clock cycles. CLKS_PER_BIT=1 gives the one-bit-per-clock timing the receiver samples at.

---
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_if                                                           |
// | Parallel-side handshake and serial line bundle for uart_tx.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface uart_tx_if;
    logic       start;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output din,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  din,
        output tx,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx                                                              |
// | UART transmitter: start bit, LSB-first data, optional parity, stop.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int             BW          = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0]  c_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [7:0]     c_DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic           c_PAR_INV   = (PARITY_ODD != 0);
    localparam logic           c_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q,   state_d;
    logic [7:0]     shift_q,   shift_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]  baud_q,    baud_d;
    logic           par_q,     par_d;
    logic           tx_q,      tx_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;
    logic           w_bit_end;

    assign w_bit_end = (baud_q == c_BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 4'd0;
            baud_q    <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx stays registered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        par_d     = par_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = w_bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d   = bus.din;
                    par_d     = ^(bus.din & c_DATA_MASK);
                    bit_cnt_d = 4'd0;
                    baud_d    = '0;
                    busy_d    = 1'b1;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = shift_q[1];
                    if (bit_cnt_q == c_DATA_LAST) begin
                        bit_cnt_d = 4'd0;
                        if (c_PAR_EN) begin
                            tx_d    = par_q ^ c_PAR_INV;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == c_STOP_LAST) begin
                        bit_cnt_d = 4'd0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx                                                           |
// | Scoreboard bench for uart_tx across several parameter sets.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();
    uart_tx_if if3 ();
    uart_tx_if if4 ();

    uart_tx #(.CLKS_PER_BIT(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    uart_tx #(.CLKS_PER_BIT(1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    function automatic exp_t mk(input logic t, input logic b, input logic d);
        exp_t e;
        e.tx = t; e.busy = b; e.done = d;
        return e;
    endfunction

    // Expected per-cycle {tx,busy,done} for one frame plus its done cycle.
    function automatic void push_frame(input logic [7:0] d, input int cpb, input int db,
                                       input int pen, input int podd, input int sb);
        logic p;
        p = podd[0];
        for (int k = 0; k < db; k++) p = p ^ d[k];
        for (int c = 0; c < cpb; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
        for (int k = 0; k < db; k++)
            for (int c = 0; c < cpb; c++) exp_q.push_back(mk(d[k], 1'b1, 1'b0));
        if (pen != 0)
            for (int c = 0; c < cpb; c++) exp_q.push_back(mk(p, 1'b1, 1'b0));
        for (int c = 0; c < cpb * sb; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
    endfunction

    task automatic test_reset();
        logic [4:0] txs;
        logic [9:0] bd;
        rst = 1'b1;
        if0.start = 0; if1.start = 0; if2.start = 0; if3.start = 0; if4.start = 0;
        if0.din = 0; if1.din = 0; if2.din = 0; if3.din = 0; if4.din = 0;
        repeat (3) @(negedge clk);
        txs = {if0.tx, if1.tx, if2.tx, if3.tx, if4.tx};
        bd  = {if0.busy, if0.done, if1.busy, if1.done, if2.busy, if2.done,
               if3.busy, if3.done, if4.busy, if4.done};
        total++;
        if (txs !== 5'b11111) begin bad++; $display("FAIL reset_tx got=%b want=11111", txs); end
        total++;
        if (bd !== 10'b0) begin bad++; $display("FAIL reset_busy_done got=%b want=0", bd); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({if0.tx, if0.busy, if0.done} !== 3'b100) begin
                bad++; $display("FAIL idle cyc=%0d got=%b want=100", i, {if0.tx, if0.busy, if0.done});
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({if0.tx, if0.busy, if0.done} !== 3'b100) begin
            bad++; $display("FAIL idle_rst got=%b want=100", {if0.tx, if0.busy, if0.done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (if0.tx !== 1'b1) begin bad++; $display("FAIL idle_rst_release got=%b want=1", if0.tx); end
    endtask

    task automatic test_frame_cpb4();
        exp_t e, o;
        int n, busy_cnt, done_cnt;
        busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        if0.din = 8'hA5; if0.start = 1'b1;
        push_frame(8'hA5, 4, 8, 0, 0, 1);
        n = exp_q.size();
        @(negedge clk);
        if0.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            o = {if0.tx, if0.busy, if0.done};
            total++;
            if (o !== e) begin bad++; $display("FAIL frame_a5 cyc=%0d got=%b want=%b", i + 1, o, e); end
            busy_cnt += int'(o.busy);
            done_cnt += int'(o.done);
        end
        total++;
        if (busy_cnt !== 40) begin bad++; $display("FAIL busy_len got=%0d want=40", busy_cnt); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_parity();
        logic [7:0] dins [3];
        logic       sels [3];
        logic       pars [3];
        exp_t e, o;
        int n, busy_cnt;
        dins = '{8'hA5, 8'h07, 8'h07};
        sels = '{1'b0, 1'b0, 1'b1};
        pars = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            busy_cnt = 0;
            @(negedge clk);
            if (sels[t]) begin if2.din = dins[t]; if2.start = 1'b1; end
            else         begin if1.din = dins[t]; if1.start = 1'b1; end
            push_frame(dins[t], 1, 8, 1, sels[t] ? 1 : 0, 1);
            n = exp_q.size();
            @(negedge clk);
            if1.start = 1'b0; if2.start = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                e = exp_q.pop_front();
                o = sels[t] ? {if2.tx, if2.busy, if2.done} : {if1.tx, if1.busy, if1.done};
                total++;
                if (o !== e) begin bad++; $display("FAIL parity_frame t=%0d cyc=%0d got=%b want=%b", t, i + 1, o, e); end
                if (i == 9) begin
                    total++;
                    if (o.tx !== pars[t]) begin bad++; $display("FAIL parity_bit t=%0d got=%b want=%b", t, o.tx, pars[t]); end
                end
                busy_cnt += int'(o.busy);
            end
            total++;
            if (busy_cnt !== 11) begin bad++; $display("FAIL parity_len t=%0d got=%0d want=11", t, busy_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int cnt, done_cnt;
        cnt = 0; done_cnt = 0;
        @(negedge clk);
        if3.din = 8'h3C; if3.start = 1'b1;
        push_frame(8'h3C, 1, 8, 0, 0, 1);
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (i == 4) begin
                if3.din = 8'hFF;
                push_frame(8'hFF, 1, 8, 0, 0, 1);
            end
            e = exp_q.pop_front();
            o = {if3.tx, if3.busy, if3.done};
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b cyc=%0d got=%b want=%b", i + 1, o, e); end
            done_cnt += int'(o.done);
            cnt++;
            if (done_cnt == 2) if3.start = 1'b0;
        end
        total++;
        if (cnt !== 22 || done_cnt !== 2) begin
            bad++; $display("FAIL b2b_len got=%0d/%0d want=22/2", cnt, done_cnt);
        end
        @(negedge clk);
        total++;
        if ({if3.tx, if3.busy, if3.done} !== 3'b100) begin
            bad++; $display("FAIL b2b_stop got=%b want=100", {if3.tx, if3.busy, if3.done});
        end
    endtask

    task automatic test_din_change();
        exp_t e, o;
        int n;
        @(negedge clk);
        if0.din = 8'h5A; if0.start = 1'b1;
        push_frame(8'h5A, 4, 8, 0, 0, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) if0.start = 1'b0;
            if (i == 4) begin if0.din = 8'h00; if0.start = 1'b1; end
            if (i == 5) if0.start = 1'b0;
            e = exp_q.pop_front();
            o = {if0.tx, if0.busy, if0.done};
            total++;
            if (o !== e) begin bad++; $display("FAIL din_change cyc=%0d got=%b want=%b", i + 1, o, e); end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if ({if0.tx, if0.busy, if0.done} !== 3'b100) begin
                bad++; $display("FAIL no_requeue cyc=%0d got=%b want=100", i, {if0.tx, if0.busy, if0.done});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e, o;
        int n, stop_run;
        stop_run = 0;
        @(negedge clk);
        if4.din = 8'h00; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({if4.tx, if4.busy} !== 2'b01) begin
            bad++; $display("FAIL pre_rst_data got=%b want=01", {if4.tx, if4.busy});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({if4.tx, if4.busy, if4.done} !== 3'b100) begin
            bad++; $display("FAIL rst_mid got=%b want=100", {if4.tx, if4.busy, if4.done});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({if4.tx, if4.busy, if4.done} !== 3'b100) begin
                bad++; $display("FAIL rst_no_done cyc=%0d got=%b want=100", i, {if4.tx, if4.busy, if4.done});
            end
        end
        if4.start = 1'b1;
        push_frame(8'h00, 2, 8, 0, 0, 2);
        n = exp_q.size();
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            o = {if4.tx, if4.busy, if4.done};
            total++;
            if (o !== e) begin bad++; $display("FAIL stop2 cyc=%0d got=%b want=%b", i + 1, o, e); end
            if (o.busy && o.tx) stop_run++;
            else if (o.busy) stop_run = 0;
        end
        total++;
        if (stop_run !== 4) begin bad++; $display("FAIL stop2_len got=%0d want=4", stop_run); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_cpb4();
        test_parity();
        test_back_to_back();
        test_din_change();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
